exposure_sequencer: RTL

//  Top-level capture controller for the pixel array. Holds the programmable exposure time,

---
 rtl/exposure_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/exposure_sequencer.sv
// Capture controller for the pixel array: programmable exposure, timer handshake,
// two-row readout sequence and a watchdog that aborts a capture if the timer stalls.
module exposure_sequencer #(
  parameter int EXP_W     = 5,
  parameter int EXP_MIN   = 2,
  parameter int EXP_MAX   = 30,
  parameter int EXP_INIT  = 2,
  parameter int WD_MARGIN = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Timer_ovf,
  output logic [EXP_W-1:0] Timer_init,
  output logic             Timer_start,
  output logic             Timer_reset,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output logic             Error
);

  localparam int WD_W = $clog2(EXP_MAX + WD_MARGIN + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(EXP_MAX + WD_MARGIN);
  localparam logic [EXP_W-1:0] EXP_HI    = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_LO    = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] EXP_RESET = EXP_W'(EXP_INIT);

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    EXPOSE,
    R0,
    R1,
    R2,
    R3,
    R4,
    R5,
    ABORT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [EXP_W-1:0]  exp_reg;
  logic [EXP_W-1:0]  exp_next;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W-1:0]   wd_next;

  assign Timer_init = exp_reg;

  // Init has priority over exposure edits; inc and dec together cancel out.
  always_comb begin
    next_state = state;
    exp_next   = exp_reg;
    wd_next    = wd_cnt;
    case (state)
      IDLE: begin
        if (Init) begin
          next_state = ARM;
        end else if (Exp_increase && !Exp_decrease) begin
          if (exp_reg < EXP_HI) exp_next = exp_reg + 1'b1;
        end else if (Exp_decrease && !Exp_increase) begin
          if (exp_reg > EXP_LO) exp_next = exp_reg - 1'b1;
        end
      end
      ARM: begin
        next_state = EXPOSE;
        wd_next    = '0;
      end
      EXPOSE: begin
        wd_next = wd_cnt + 1'b1;
        if (Timer_ovf) begin
          next_state = R0;
        end else if (wd_cnt + 1'b1 == WD_LIMIT) begin
          next_state = ABORT;
        end
      end
      R0:      next_state = R1;
      R1:      next_state = R2;
      R2:      next_state = R3;
      R3:      next_state = R4;
      R4:      next_state = R5;
      R5:      next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so every strobe lines up with its state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      exp_reg     <= EXP_RESET;
      wd_cnt      <= '0;
      Erase       <= 1'b1;
      Expose      <= 1'b0;
      NRE_1       <= 1'b1;
      NRE_2       <= 1'b1;
      ADC         <= 1'b0;
      Timer_start <= 1'b0;
      Timer_reset <= 1'b0;
      Busy        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state       <= next_state;
      exp_reg     <= exp_next;
      wd_cnt      <= wd_next;
      Erase       <= (next_state == IDLE);
      Expose      <= (next_state == EXPOSE);
      NRE_1       <= !(next_state == R0 || next_state == R1);
      NRE_2       <= !(next_state == R3 || next_state == R4);
      ADC         <= (next_state == R1 || next_state == R4);
      Timer_start <= (next_state == ARM);
      Timer_reset <= (next_state == ABORT);
      Busy        <= (next_state != IDLE);
      if (next_state == ABORT) begin
        Error <= 1'b1;
      end else if (state == IDLE && Init) begin
        Error <= 1'b0;
      end
    end
  end

endmodule
